// File: rtl/fixed_pkg.sv
// Shared constants, FSM states and saturation helper for the fixed-point math units.
// Used by fixed_square and its fixed_sqrt companion.
package fixed_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;
  localparam int MAX_W     = 32;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  // Returns {value, ovf}; callers truncate to (width+1) bits to get their own result and flag.
  function automatic logic [MAX_W:0] sat_shift(input logic [2*MAX_W-1:0] prod,
                                               input int unsigned       width,
                                               input int unsigned       frac);
    logic [2*MAX_W-1:0] p;
    logic [MAX_W-1:0]   ones;
    logic               ovf;
    p    = prod >> frac;
    ones = {MAX_W{1'b1}} >> (MAX_W - width);
    ovf  = (p >> width) != '0;
    return {(ovf ? ones : p[MAX_W-1:0]), ovf};
  endfunction

endpackage

// File: rtl/fixed_square.sv
// Sequential unsigned fixed-point squarer, one shift-add step per cycle, truncating/saturating result.
// Latency: WIDTH+1 cycles from start edge to done; back-to-back throughput WIDTH+2 cycles.
// Backpressure: start is ignored (not queued) while busy; result holds until the next completion.
module fixed_square
  import fixed_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  output logic [WIDTH-1:0] sq_out,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * MAX_W;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Truncating the helper's {value, ovf} keeps value[WIDTH-1:0] and the flag.
  assign sat = (WIDTH+1)'(sat_shift(PW'(acc), WIDTH, FRAC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sq_out <= '0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= (2*WIDTH)'(x_in);
            mplier <= x_in;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
        end
        FINISH: begin
          sq_out <= sat[WIDTH:1];
          ovf    <= sat[0];
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
